// File: rtl/heartbeat_supervisor.sv
// heartbeat_supervisor
//   Supervises the Ariane core through an external heartbeat path-selector
//   timer. It keeps the timer armed, kicks it on every core heartbeat, and
//   runs a revive sequence when the timer times out: a timed core reset pulse
//   followed by a boot grace period. After MAX_RETRIES consecutive revives
//   without a good heartbeat, it latches a sticky fault and holds the core in
//   reset until clr_fault.
//
// Parameters
//   REVIVE_CYCLES  cycles core_rst_n is held low per revive (1..65535)
//   BOOT_CYCLES    grace cycles after a revive before re-arming (1..65535)
//   MAX_RETRIES    consecutive revives allowed before FAULT (1..255)
//
// Ports
//   clk           system clock
//   rstn          asynchronous active-low reset
//   enable        supervision enable (level)
//   hb_pulse      core heartbeat, single-cycle pulse
//   clr_fault     fault clear, single-cycle pulse (only acted on in FAULT)
//   sel_wait_end  timer wait_end_signal
//   sel_path      timer path_signal (1 = timeout)
//   sel_start     timer start_signal
//   sel_reset     timer reset_signal
//   core_rst_n    core reset request, active low
//   fault         retries exhausted, sticky until clr_fault
//   retry_cnt     consecutive revives since the last good heartbeat
//   revive_total  total revives since rstn, saturating at 255
//   state         current FSM state encoding

module heartbeat_supervisor #(
    parameter int unsigned REVIVE_CYCLES = 16,
    parameter int unsigned BOOT_CYCLES   = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       hb_pulse,
    input  logic       clr_fault,
    input  logic       sel_wait_end,
    input  logic       sel_path,
    output logic       sel_start,
    output logic       sel_reset,
    output logic       core_rst_n,
    output logic       fault,
    output logic [7:0] retry_cnt,
    output logic [7:0] revive_total,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT    = 3'd2,
        KICK    = 3'd3,
        REVIVE  = 3'd4,
        RECOVER = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [15:0] REVIVE_LOAD = 16'(REVIVE_CYCLES);
    localparam logic [15:0] BOOT_LOAD   = 16'(BOOT_CYCLES);
    localparam logic [7:0]  RETRY_MAX   = 8'(MAX_RETRIES);

    state_t      cur;
    logic        hb_pend;
    logic [15:0] phase_cnt;
    logic [7:0]  retry_q;
    logic [7:0]  total_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur       <= IDLE;
            hb_pend   <= 1'b0;
            phase_cnt <= '0;
            retry_q   <= '0;
            total_q   <= '0;
        end else begin
            case (cur)
                IDLE: begin
                    hb_pend <= 1'b0;
                    if (enable) begin
                        cur <= ARM;
                    end
                end

                // One-cycle hold-off so the timer can drop a stale wait_end;
                // a heartbeat landing here is remembered for WAIT.
                ARM: begin
                    if (hb_pulse) begin
                        hb_pend <= 1'b1;
                    end
                    cur <= enable ? WAIT : IDLE;
                end

                // Heartbeat has priority over a simultaneous timeout.
                WAIT: begin
                    if (!enable) begin
                        cur <= IDLE;
                    end else if (hb_pulse || hb_pend) begin
                        cur     <= KICK;
                        hb_pend <= 1'b0;
                        retry_q <= '0;
                    end else if (sel_path && sel_wait_end) begin
                        if (retry_q < RETRY_MAX) begin
                            cur       <= REVIVE;
                            retry_q   <= retry_q + 8'd1;
                            phase_cnt <= REVIVE_LOAD;
                            if (total_q != 8'hFF) begin
                                total_q <= total_q + 8'd1;
                            end
                        end else begin
                            cur <= FAULT;
                        end
                    end
                end

                KICK: begin
                    if (hb_pulse) begin
                        hb_pend <= 1'b1;
                    end
                    cur <= ARM;
                end

                // Reset pulse runs to completion regardless of enable.
                REVIVE: begin
                    hb_pend <= 1'b0;
                    if (phase_cnt == 16'd1) begin
                        cur       <= RECOVER;
                        phase_cnt <= BOOT_LOAD;
                    end else begin
                        phase_cnt <= phase_cnt - 16'd1;
                    end
                end

                // Boot grace also runs to completion; enable is only looked
                // at on expiry to choose between re-arming and going idle.
                RECOVER: begin
                    if (hb_pulse) begin
                        hb_pend <= 1'b1;
                    end
                    phase_cnt <= phase_cnt - 16'd1;
                    if (phase_cnt == 16'd1) begin
                        cur <= enable ? ARM : IDLE;
                    end
                end

                FAULT: begin
                    hb_pend <= 1'b0;
                    if (clr_fault) begin
                        retry_q <= '0;
                        cur     <= IDLE;
                    end
                end

                default: begin
                    cur <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode directly from registered state.
    assign sel_start    = (cur == ARM) || (cur == WAIT) || (cur == KICK);
    assign sel_reset    = (cur == KICK);
    assign core_rst_n   = !((cur == REVIVE) || (cur == FAULT));
    assign fault        = (cur == FAULT);
    assign retry_cnt    = retry_q;
    assign revive_total = total_q;
    assign state        = cur;

endmodule

// File: tb/tb_heartbeat_supervisor.sv
// tb_heartbeat_supervisor
//   Self-checking bench for heartbeat_supervisor. A path-selector timer with a
//   100-cycle timeout is modelled in the bench and fed from the expected
//   start/reset outputs. A reference model tracks the supervisor as phases
//   with absolute end times; every cycle all outputs are compared against it.
//   Directed scenarios cover the documented behaviours, followed by a
//   randomized run.

module tb_heartbeat_supervisor;

    localparam int R    = 16;
    localparam int B    = 1024;
    localparam int MAXR = 3;
    localparam int TMO  = 100;

    logic       clk;
    logic       rstn;
    logic       enable;
    logic       hb_pulse;
    logic       clr_fault;
    logic       sel_wait_end;
    logic       sel_path;
    logic       sel_start;
    logic       sel_reset;
    logic       core_rst_n;
    logic       fault;
    logic [7:0] retry_cnt;
    logic [7:0] revive_total;
    logic [2:0] state;

    heartbeat_supervisor #(
        .REVIVE_CYCLES(R),
        .BOOT_CYCLES  (B),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .hb_pulse    (hb_pulse),
        .clr_fault   (clr_fault),
        .sel_wait_end(sel_wait_end),
        .sel_path    (sel_path),
        .sel_start   (sel_start),
        .sel_reset   (sel_reset),
        .core_rst_n  (core_rst_n),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .revive_total(revive_total),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode uses the documented state numbers; timed phases
    // are tracked by the absolute cycle at which they end.
    int          m_st;
    int          m_retry;
    int          m_total;
    bit          m_pend;
    int unsigned m_end;
    int unsigned t;
    int          tcnt;
    bit          coinc_mode;
    bit          coinc_hit;
    int          n_low;
    int          n_rec;
    int          n_kick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, t);
            if (errors >= 25) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    task automatic model_reset();
        m_st         = 0;
        m_retry      = 0;
        m_total      = 0;
        m_pend       = 0;
        m_end        = 0;
        tcnt         = 0;
        sel_path     = 1'b0;
        sel_wait_end = 1'b0;
    endtask

    function automatic bit exp_start(input int s);
        return (s == 1) || (s == 2) || (s == 3);
    endfunction

    // Advance model by one clock edge using the inputs presented before it.
    task automatic model_step();
        int ns;
        ns = m_st;
        // timer: counts while started and not reset
        if (!exp_start(m_st) || (m_st == 3)) tcnt = 0;
        else if (tcnt < 1000) tcnt++;
        case (m_st)
            0: begin
                m_pend = 0;
                if (enable) ns = 1;
            end
            1: begin
                if (hb_pulse) m_pend = 1;
                ns = enable ? 2 : 0;
            end
            2: begin
                if (!enable) ns = 0;
                else if (hb_pulse || m_pend) begin
                    ns = 3; m_pend = 0; m_retry = 0;
                end else if (sel_path && sel_wait_end) begin
                    if (m_retry < MAXR) begin
                        ns = 4;
                        m_retry++;
                        if (m_total < 255) m_total++;
                        m_end = t + R;
                    end else ns = 6;
                end
            end
            3: begin
                if (hb_pulse) m_pend = 1;
                ns = 1;
            end
            4: begin
                m_pend = 0;
                if (t == m_end) begin
                    ns = 5;
                    m_end = t + B;
                end
            end
            5: begin
                if (hb_pulse) m_pend = 1;
                if (t == m_end) ns = enable ? 1 : 0;
            end
            default: begin
                m_pend = 0;
                if (clr_fault) begin
                    ns = 0; m_retry = 0;
                end
            end
        endcase
        m_st = ns;
    endtask

    task automatic compare_all();
        check("state", state, m_st);
        check("sel_start", sel_start, exp_start(m_st));
        check("sel_reset", sel_reset, m_st == 3);
        check("core_rst_n", core_rst_n, !((m_st == 4) || (m_st == 6)));
        check("fault", fault, m_st == 6);
        check("retry_cnt", retry_cnt, m_retry);
        check("revive_total", revive_total, m_total);
        if (core_rst_n === 1'b0) n_low++;
        if (state === 3'd5) n_rec++;
        if (sel_reset === 1'b1) n_kick++;
    endtask

    // One clock cycle: edge, model update, sample at +1, then drive next inputs.
    task automatic tick();
        @(posedge clk);
        t++;
        if (rstn) model_step();
        #1;
        compare_all();
        hb_pulse     = 1'b0;
        clr_fault    = 1'b0;
        sel_path     = (tcnt == TMO);
        sel_wait_end = (tcnt >= TMO);
        if (coinc_mode && (tcnt == TMO) && (m_st == 2)) begin
            hb_pulse  = 1'b1;
            coinc_hit = 1'b1;
        end
    endtask

    task automatic run_until(input int target, input int bound);
        for (int i = 0; i < bound && m_st != target; i++) tick();
        check("reach_state", m_st, target);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; hb_pulse = 1'b0; clr_fault = 1'b0;
        coinc_mode = 0; coinc_hit = 0; t = 0;
        n_low = 0; n_rec = 0; n_kick = 0;
        model_reset();
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();

        // Regular heartbeat every 50 cycles: 20 one-cycle kicks, no revive.
        enable = 1'b1;
        repeat (5) tick();
        n_kick = 0; n_low = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 49) hb_pulse = 1'b1;
            tick();
        end
        check("s1_kicks", n_kick, 20);
        check("s1_low", n_low, 0);
        check("s1_retry", retry_cnt, 0);
        check("s1_total", revive_total, 0);

        // No heartbeat: one full revive back to WAIT.
        n_low = 0; n_rec = 0;
        repeat (1200) tick();
        check("s2_low", n_low, 16);
        check("s2_recover", n_rec, 1024);
        check("s2_retry", retry_cnt, 1);
        check("s2_total", revive_total, 1);
        check("s2_state", state, 2);

        // Keep starving: two more revives then FAULT.
        run_until(6, 5000);
        check("s3_fault", fault, 1);
        check("s3_core_rst_n", core_rst_n, 0);
        check("s3_retry", retry_cnt, 3);
        check("s3_total", revive_total, 3);
        for (int i = 0; i < 40; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
        end
        check("s3_sticky", state, 6);
        enable = 1'b0;
        clr_fault = 1'b1;
        tick();
        check("s3_clr_state", state, 0);
        check("s3_clr_fault", fault, 0);
        check("s3_clr_retry", retry_cnt, 0);
        clr_fault = 1'b1;
        tick();
        check("s3_clr_idle", state, 0);

        // Enable dropped on the 5th REVIVE cycle: full pulse, full boot, IDLE.
        enable = 1'b1;
        n_low = 0; n_rec = 0;
        run_until(4, 400);
        repeat (4) tick();
        enable = 1'b0;
        run_until(0, 1300);
        check("s5_low", n_low, 16);
        check("s5_recover", n_rec, 1024);
        check("s5_sel_start", sel_start, 0);
        check("s5_retry", retry_cnt, 1);
        check("s5_total", revive_total, 4);

        // Heartbeat and timeout in the same WAIT cycle: KICK wins.
        enable = 1'b1;
        coinc_mode = 1; coinc_hit = 0;
        for (int i = 0; i < 300 && !coinc_hit; i++) tick();
        coinc_mode = 0;
        check("s4_coinc_seen", coinc_hit, 1);
        tick();
        check("s4_kick", state, 3);
        check("s4_retry", retry_cnt, 0);
        check("s4_total", revive_total, 4);

        // Asynchronous reset on the 8th REVIVE cycle.
        run_until(4, 400);
        repeat (7) tick();
        check("s6_in_revive", core_rst_n, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("s6_core_rst_n", core_rst_n, 1);
        check("s6_state", state, 0);
        check("s6_sel_start", sel_start, 0);
        check("s6_sel_reset", sel_reset, 0);
        check("s6_fault", fault, 0);
        check("s6_retry", retry_cnt, 0);
        check("s6_total", revive_total, 0);
        model_reset();
        repeat (2) tick();
        rstn = 1'b1;

        // Randomized run: dense heartbeats, then sparse ones to reach FAULT.
        for (int i = 0; i < 8000; i++) begin
            if (i < 3000) hb_pulse = ($urandom_range(0, 59) == 0);
            else          hb_pulse = ($urandom_range(0, 2999) == 0);
            if (enable) begin
                if ($urandom_range(0, 399) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) enable = 1'b1;
            end
            clr_fault = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
